// File: rtl/paddle_ctrl.sv
// paddle_ctrl: vertical paddle position controller for the pong playfield.
// A free-running divider produces move ticks; on each tick a three-state
// direction FSM (IDLE/UP/DN) moves the paddle by a step that ramps up while
// the same direction is held. Direction comes from the keys or, in AI mode,
// from comparing the ball y against the paddle centre. All outputs are
// registered and change on the edge that ends the tick cycle.
module paddle_ctrl #(
  parameter int X_POS      = 55,
  parameter int Y_INIT     = 200,
  parameter int PADDLE_LEN = 80,
  parameter int Y_MIN      = 10,
  parameter int Y_MAX      = 390,
  parameter int DIV_SLOW   = 190000,
  parameter int DIV_FAST   = 80000,
  parameter int STEP_MIN   = 2,
  parameter int STEP_MAX   = 6,
  parameter int RAMP_TICKS = 8,
  parameter int DEADBAND   = 4
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic [1:0] key_n,
  input  logic       fast,
  input  logic       recenter,
  input  logic       ai_en,
  input  logic [9:0] ball_y,
  output logic [9:0] body_x,
  output logic [9:0] body_y,
  output logic       moving,
  output logic       at_top,
  output logic       at_bottom
);

  localparam int DIV_BIG = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int DIV_W   = $clog2(DIV_BIG + 1);
  localparam int STEP_W  = $clog2(STEP_MAX + 1);
  localparam int RUN_W   = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  localparam logic [DIV_W-1:0]  DIV_SLOW_M1 = DIV_W'(DIV_SLOW - 1);
  localparam logic [DIV_W-1:0]  DIV_FAST_M1 = DIV_W'(DIV_FAST - 1);
  localparam logic [STEP_W-1:0] STEP_MIN_W  = STEP_W'(STEP_MIN);
  localparam logic [STEP_W-1:0] STEP_MAX_W  = STEP_W'(STEP_MAX);
  localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(RAMP_TICKS - 1);
  localparam logic [10:0]       Y_MIN_W     = 11'(Y_MIN);
  localparam logic [10:0]       Y_MAX_W     = 11'(Y_MAX);
  localparam logic [10:0]       HALF_LEN_W  = 11'(PADDLE_LEN / 2);
  localparam logic [10:0]       DEAD_W      = 11'(DEADBAND);
  localparam logic [9:0]        Y_INIT_10   = 10'(Y_INIT);
  localparam logic [9:0]        Y_MIN_10    = 10'(Y_MIN);
  localparam logic [9:0]        Y_MAX_10    = 10'(Y_MAX);
  localparam logic [9:0]        X_POS_10    = 10'(X_POS);

  // IDLE doubles as the "no request" value of the direction request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } state_t;

  state_t             state_q, state_d, req;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d, div_lim;
  logic               tick;
  logic [STEP_W-1:0]  step_q, step_d, move_amt;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [9:0]         y_d;
  logic [10:0]        cur_y, sum_y, up_floor, centre, ball_w;

  // Move-tick divider: ">=" so a slow-to-fast switch never overshoots the new period.
  always_comb begin
    div_lim   = fast ? DIV_FAST_M1 : DIV_SLOW_M1;
    tick      = (div_cnt_q >= div_lim);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  // Direction request from the keys, or from ball tracking with a deadband in AI mode.
  always_comb begin
    req    = IDLE;
    centre = {1'b0, body_y} + HALF_LEN_W;
    ball_w = {1'b0, ball_y};
    if (ai_en) begin
      if (ball_w > centre + DEAD_W)      req = DN;
      else if (ball_w + DEAD_W < centre) req = UP;
    end else begin
      case (key_n)
        2'b10:   req = DN;
        2'b01:   req = UP;
        default: req = IDLE;
      endcase
    end
  end

  // FSM next state, step ramp and saturating move; recenter overrides any tick.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    run_cnt_d = run_cnt_q;
    move_amt  = '0;
    cur_y     = {1'b0, body_y};
    sum_y     = '0;
    up_floor  = '0;
    y_d       = body_y;
    if (recenter) begin
      state_d   = IDLE;
      step_d    = STEP_MIN_W;
      run_cnt_d = '0;
      y_d       = Y_INIT_10;
    end else if (tick) begin
      if (req == IDLE) begin
        state_d   = IDLE;
        step_d    = STEP_MIN_W;
        run_cnt_d = '0;
      end else begin
        if (req != state_q) begin
          // New direction or reversal restarts the ramp.
          state_d   = req;
          step_d    = STEP_MIN_W;
          run_cnt_d = '0;
          move_amt  = STEP_MIN_W;
        end else begin
          move_amt = step_q;
          if (run_cnt_q == RUN_LAST) begin
            run_cnt_d = '0;
            step_d    = (step_q >= STEP_MAX_W) ? STEP_MAX_W : step_q + 1'b1;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        sum_y    = cur_y + 11'(move_amt);
        up_floor = Y_MIN_W + 11'(move_amt);
        if (req == DN) begin
          y_d = (sum_y > Y_MAX_W) ? Y_MAX_10 : sum_y[9:0];
        end else begin
          // Compare before subtracting so the position can never wrap below zero.
          y_d = (cur_y < up_floor) ? Y_MIN_10 : 10'(cur_y - 11'(move_amt));
        end
      end
    end
  end

  // State, ramp, divider and registered outputs.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      div_cnt_q <= '0;
      state_q   <= IDLE;
      step_q    <= STEP_MIN_W;
      run_cnt_q <= '0;
      body_y    <= Y_INIT_10;
      body_x    <= X_POS_10;
      moving    <= 1'b0;
      at_top    <= (Y_INIT_10 == Y_MIN_10);
      at_bottom <= (Y_INIT_10 == Y_MAX_10);
    end else begin
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      step_q    <= step_d;
      run_cnt_q <= run_cnt_d;
      body_y    <= y_d;
      body_x    <= X_POS_10;
      moving    <= (state_d != IDLE);
      at_top    <= (y_d == Y_MIN_10);
      at_bottom <= (y_d == Y_MAX_10);
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed phases followed by randomized stimulus. A reference
// model tracks paddle position, direction and ramp with plain integer
// arithmetic and pushes the expected outputs for every clock edge into a
// queue; a monitor pops one entry per cycle and compares.
module tb_paddle_ctrl;

  localparam int X_POS      = 55;
  localparam int Y_INIT     = 200;
  localparam int PADDLE_LEN = 80;
  localparam int Y_MIN      = 10;
  localparam int Y_MAX      = 390;
  localparam int DIV_SLOW   = 8;
  localparam int DIV_FAST   = 4;
  localparam int STEP_MIN   = 2;
  localparam int STEP_MAX   = 6;
  localparam int RAMP_TICKS = 8;
  localparam int DEADBAND   = 4;
  localparam int EW         = 23;

  logic       vga_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] key_n = 2'b11;
  logic       fast = 1'b0;
  logic       recenter = 1'b0;
  logic       ai_en = 1'b0;
  logic [9:0] ball_y = 10'd0;
  logic [9:0] body_x, body_y;
  logic       moving, at_top, at_bottom;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state (signed integers, direction -1/0/+1).
  int m_y    = Y_INIT;
  int m_dir  = 0;
  int m_step = STEP_MIN;
  int m_run  = 0;
  int m_cnt  = 0;

  paddle_ctrl #(
    .X_POS(X_POS), .Y_INIT(Y_INIT), .PADDLE_LEN(PADDLE_LEN), .Y_MIN(Y_MIN),
    .Y_MAX(Y_MAX), .DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST), .STEP_MIN(STEP_MIN),
    .STEP_MAX(STEP_MAX), .RAMP_TICKS(RAMP_TICKS), .DEADBAND(DEADBAND)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .key_n(key_n), .fast(fast),
    .recenter(recenter), .ai_en(ai_en), .ball_y(ball_y), .body_x(body_x),
    .body_y(body_y), .moving(moving), .at_top(at_top), .at_bottom(at_bottom)
  );

  // Clock
  always #5 vga_clk = ~vga_clk;

  function automatic int want_dir(int y, logic [1:0] keys, logic ai, int ball);
    int c;
    if (ai) begin
      c = y + PADDLE_LEN / 2;
      if (ball > c + DEADBAND) return 1;
      if (ball < c - DEADBAND) return -1;
      return 0;
    end
    if (keys == 2'b10) return 1;
    if (keys == 2'b01) return -1;
    return 0;
  endfunction

  function automatic logic [EW-1:0] pack_exp(int y, int dir);
    logic [9:0] yv;
    yv = 10'(y);
    return {10'(X_POS), yv, (dir != 0), (y == Y_MIN), (y == Y_MAX)};
  endfunction

  // Reference model: one expected output vector per rising edge.
  initial begin
    int period, want, amt;
    bit tk;
    forever begin
      @(posedge vga_clk);
      cyc++;
      if (sys_rst) begin
        m_cnt = 0; m_dir = 0; m_step = STEP_MIN; m_run = 0; m_y = Y_INIT;
      end else begin
        period = fast ? DIV_FAST : DIV_SLOW;
        tk = (m_cnt + 1 >= period);
        m_cnt = tk ? 0 : m_cnt + 1;
        if (recenter) begin
          m_y = Y_INIT; m_dir = 0; m_step = STEP_MIN; m_run = 0;
        end else if (tk) begin
          want = want_dir(m_y, key_n, ai_en, int'(ball_y));
          if (want == 0) begin
            m_dir = 0; m_step = STEP_MIN; m_run = 0;
          end else begin
            if (want != m_dir) begin
              m_dir = want; m_step = STEP_MIN; m_run = 0; amt = STEP_MIN;
            end else begin
              amt = m_step;
              m_run++;
              if (m_run == RAMP_TICKS) begin
                m_run = 0;
                m_step = (m_step + 1 > STEP_MAX) ? STEP_MAX : m_step + 1;
              end
            end
            m_y = m_y + want * amt;
            if (m_y > Y_MAX) m_y = Y_MAX;
            if (m_y < Y_MIN) m_y = Y_MIN;
          end
        end
      end
      exp_q.push_back(pack_exp(m_y, m_dir));
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation, away from the edge.
  initial begin
    logic [EW-1:0] exp_v, got_v;
    forever begin
      @(negedge vga_clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {body_x, body_y, moving, at_top, at_bottom};
        n_checks++;
        if (got_v !== exp_v) begin
          n_errors++;
          $display("FAIL outputs cyc=%0d: got x=%0d y=%0d mv=%b top=%b bot=%b, exp x=%0d y=%0d mv=%b top=%b bot=%b",
                   cyc, got_v[22:13], got_v[12:3], got_v[2], got_v[1], got_v[0],
                   exp_v[22:13], exp_v[12:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // Driver tasks: inputs change on the falling edge.
  task automatic run_cycles(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    run_cycles(n);
    sys_rst = 1'b0;
  endtask

  task automatic set_in(input logic [1:0] k, input logic f, input logic ai, input int b);
    key_n = k; fast = f; ai_en = ai; ball_y = 10'(b);
  endtask

  // Stimulus
  initial begin
    bit found;
    do_reset(3);

    // Hold down from centre through the ramp to the bottom clamp.
    set_in(2'b10, 1'b0, 1'b0, 0);
    run_cycles(500);

    // Hold up to the top clamp, with fast ticks.
    set_in(2'b01, 1'b1, 1'b0, 0);
    run_cycles(600);

    // Nudge down one tick, then up to saturate from just above the limit.
    set_in(2'b10, 1'b0, 1'b0, 0);
    run_cycles(8);
    set_in(2'b11, 1'b0, 1'b0, 0);
    run_cycles(8);
    set_in(2'b01, 1'b0, 1'b0, 0);
    run_cycles(24);

    // Ramp to full step, reverse, then release both keys.
    recenter = 1'b1; run_cycles(1); recenter = 1'b0;
    set_in(2'b10, 1'b1, 1'b0, 0);
    run_cycles(33 * DIV_FAST);
    set_in(2'b01, 1'b1, 1'b0, 0);
    run_cycles(3 * DIV_FAST);
    set_in(2'b00, 1'b1, 1'b0, 0);
    run_cycles(5 * DIV_FAST);

    // AI tracking toward ball_y=300, then a ball inside the deadband.
    recenter = 1'b1; run_cycles(1); recenter = 1'b0;
    set_in(2'b11, 1'b0, 1'b1, 300);
    run_cycles(300);
    recenter = 1'b1; run_cycles(1); recenter = 1'b0;
    set_in(2'b11, 1'b0, 1'b1, 242);
    run_cycles(40);

    // Recenter mid-ramp, then switch to fast with the divider at 6.
    set_in(2'b10, 1'b0, 1'b0, 0);
    run_cycles(200);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_cnt == 5) begin
        found = 1;
        break;
      end
      run_cycles(1);
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL divider_align: got no cycle with count 5 in 20, required one");
    end
    recenter = 1'b1;
    run_cycles(1);
    recenter = 1'b0;
    fast = 1'b1;
    run_cycles(20);

    // Randomized phase.
    for (int seg = 0; seg < 150; seg++) begin
      set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), int'($urandom_range(0, 600)));
      if ($urandom_range(0, 40) == 0) begin
        recenter = 1'b1; run_cycles(1); recenter = 1'b0;
      end
      if ($urandom_range(0, 60) == 0) do_reset(2);
      run_cycles($urandom_range(1, 40));
    end

    run_cycles(2);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
